// File: rtl/uart_hex_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper
// for the hex debug printer. Optional macro: HEX_PREFIX_EN.
package uart_hex_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A_OFS = 8'h37;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_X     = 8'h78;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef HEX_PREFIX_EN
        ST_PFX0,
        ST_PFX1,
`endif
        ST_NIB,
        ST_EOL0,
        ST_EOL1
    } state_t;

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        logic [7:0] base;
        base = (n < 4'd10) ? ASC_0 : ASC_A_OFS;
        return base + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_hex_fifo.sv
// Single-clock word FIFO feeding the hex printer.
// Push is refused while full, even alongside a pop.
module uart_hex_fifo
    import uart_hex_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdat,
    input  logic                     pop,
    output logic [W-1:0]             rdat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdat    = mem[rptr];
    assign cnt     = cnt_q;

    // storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdat;
        end
    end

    // pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// Prints buffered words as uppercase hex lines into a UART byte port.
// Optional macro: HEX_PREFIX_EN adds a "0x" prefix to every line.
module uart_hex_tx
    import uart_hex_pkg::*;
#(
    parameter int W        = 32,
    parameter int DEPTH    = 16,
    parameter int EOL_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             in_dat,
    input  logic                     in_val,
    output logic                     in_rdy,
    output logic [7:0]               out_dat,
    output logic                     out_val,
    input  logic                     out_cts,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     busy
);

    localparam int NN = W / 4;
    localparam int CW = $clog2(NN + 1);

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  shift;
    logic [W-1:0]  shift_n;
    logic [CW-1:0] ncnt;
    logic [CW-1:0] ncnt_n;
    logic [7:0]    byte_n;
    logic          pop;
    logic          hs;
    logic [W-1:0]  fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;

    uart_hex_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_val),
        .wdat  (in_dat),
        .pop   (pop),
        .rdat  (fifo_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    assign in_rdy = !fifo_full;
    assign busy   = (state != ST_IDLE);
    assign hs     = out_val && out_cts;

    // next state, shift register and nibble counter
    always_comb begin
        state_n = state;
        shift_n = shift;
        ncnt_n  = ncnt;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dat;
                    ncnt_n  = CW'(NN);
`ifdef HEX_PREFIX_EN
                    state_n = ST_PFX0;
`else
                    state_n = ST_NIB;
`endif
                end
            end
`ifdef HEX_PREFIX_EN
            ST_PFX0: if (hs) state_n = ST_PFX1;
            ST_PFX1: if (hs) state_n = ST_NIB;
`endif
            ST_NIB: begin
                if (hs) begin
                    shift_n = shift << 4;
                    ncnt_n  = ncnt - CW'(1);
                    if (ncnt == CW'(1)) state_n = ST_EOL0;
                end
            end
            ST_EOL0: begin
                if (hs) state_n = (EOL_MODE == 0) ? ST_EOL1 : ST_IDLE;
            end
            ST_EOL1: if (hs) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // byte to present once the next state is entered
    always_comb begin
        byte_n = 8'h00;
        unique case (state_n)
`ifdef HEX_PREFIX_EN
            ST_PFX0: byte_n = ASC_0;
            ST_PFX1: byte_n = ASC_X;
`endif
            ST_NIB:  byte_n = nib2asc(shift_n[W-1 -: 4]);
            ST_EOL0: byte_n = (EOL_MODE == 0) ? ASC_CR : ASC_LF;
            ST_EOL1: byte_n = ASC_LF;
            default: byte_n = 8'h00;
        endcase
    end

    // state, datapath and registered output byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            shift   <= '0;
            ncnt    <= '0;
            out_val <= 1'b0;
            out_dat <= 8'h00;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            ncnt    <= ncnt_n;
            out_val <= (state_n != ST_IDLE);
            out_dat <= byte_n;
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx: default 32-bit CR LF instance
// plus an 8-bit LF-only instance. Honours HEX_PREFIX_EN.
module tb_uart_hex_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_dat = '0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [7:0]  out_dat;
    logic        out_val;
    logic        out_cts = 1'b0;
    logic [4:0]  fifo_cnt;
    logic        busy;

    logic [7:0]  in_dat8 = '0;
    logic        in_val8 = 1'b0;
    logic        in_rdy8;
    logic [7:0]  out_dat8;
    logic        out_val8;
    logic        out_cts8 = 1'b1;
    logic [2:0]  fifo_cnt8;
    logic        busy8;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_hex_tx #(.W(32), .DEPTH(16), .EOL_MODE(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_dat  (out_dat),
        .out_val  (out_val),
        .out_cts  (out_cts),
        .fifo_cnt (fifo_cnt),
        .busy     (busy)
    );

    uart_hex_tx #(.W(8), .DEPTH(4), .EOL_MODE(1)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat8),
        .in_val   (in_val8),
        .in_rdy   (in_rdy8),
        .out_dat  (out_dat8),
        .out_val  (out_val8),
        .out_cts  (out_cts8),
        .fifo_cnt (fifo_cnt8),
        .busy     (busy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_line(input logic [63:0] word, input int w,
                            input bit crlf);
`ifdef HEX_PREFIX_EN
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
`endif
        for (int i = w / 4 - 1; i >= 0; i--) begin
            logic [3:0] n;
            n = word[i*4 +: 4];
            if (n < 4'd10) exp_q.push_back(8'h30 + 8'(n));
            else exp_q.push_back(8'h41 + 8'(n) - 8'd10);
        end
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic collect(input bit rnd, input int budget);
        int cyc;
        bit stalled;
        logic [7:0] held;
        cyc = 0;
        stalled = 0;
        held = '0;
        while (exp_q.size() > 0 && cyc < budget) begin
            out_cts = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk("stall_val", out_val, 1);
                chk("stall_dat", out_dat, held);
            end
            stalled = out_val && !out_cts;
            held = out_dat;
            if (out_val && out_cts) chk("byte", out_dat, exp_q.pop_front());
            step();
            cyc++;
        end
        chk("collect_left", exp_q.size(), 0);
        out_cts = 1'b1;
    endtask

`ifdef HEX_PREFIX_EN
    localparam int N1 = 12;
    logic [7:0] seq1 [N1] = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34,
                             8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    localparam int NP = 12;
    logic [7:0] seqp [NP] = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30,
                             8'h30, 8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A};
    localparam int N8 = 5;
    logic [7:0] seq8 [2*N8] = '{8'h30, 8'h78, 8'h41, 8'h35, 8'h0A,
                               8'h30, 8'h78, 8'h33, 8'h43, 8'h0A};
`else
    localparam int N1 = 10;
    logic [7:0] seq1 [N1] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41,
                             8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    localparam int NP = 10;
    logic [7:0] seqp [NP] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                             8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A};
    localparam int N8 = 3;
    logic [7:0] seq8 [2*N8] = '{8'h41, 8'h35, 8'h0A,
                               8'h33, 8'h43, 8'h0A};
`endif

    initial begin
        int acc;

        // reset values
        step();
        chk("rst_out_val", out_val, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_val8", out_val8, 0);
        rst = 1'b1;
        step();

        // one word, cts high: consecutive bytes, t+2 latency
        out_cts = 1'b1;
        in_dat = 32'h1234ABCD;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
        chk("lat_t1_val", out_val, 0);
        chk("lat_t1_cnt", fifo_cnt, 1);
        step();
        chk("lat_t2_val", out_val, 1);
        chk("lat_t2_cnt", fifo_cnt, 0);
        chk("lat_t2_busy", busy, 1);
        for (int i = 0; i < N1; i++) begin
            chk("t1_val", out_val, 1);
            chk("t1_dat", out_dat, seq1[i]);
            step();
        end
        chk("t1_busy_end", busy, 0);
        chk("t1_val_end", out_val, 0);

        // same word with random stalls
        in_dat = 32'h1234ABCD;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
        add_line(64'h1234ABCD, 32, 1);
        collect(1, 600);
        step();

        // fill with cts low: DEPTH+1 accepted
        out_cts = 1'b0;
        acc = 0;
        for (int i = 0; i < 18; i++) begin
            in_val = 1'b1;
            in_dat = 32'h10000000 + 32'(i) * 32'h01010101 + 32'h9;
            if (in_rdy) begin
                acc++;
                add_line(64'(in_dat), 32, 1);
            end
            step();
        end
        chk("fill_rdy", in_rdy, 0);
        in_val = 1'b0;
        chk("fill_acc", acc, 17);
        chk("fill_cnt", fifo_cnt, 16);
        chk("fill_busy", busy, 1);
        collect(0, 2500);
        step();
        chk("drain_cnt", fifo_cnt, 0);
        chk("drain_busy", busy, 0);

        // reset in the middle of a line
        out_cts = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_val = 1'b1;
            in_dat = 32'hDEAD0001 + 32'(i);
            step();
        end
        in_val = 1'b0;
        out_cts = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_cnt", fifo_cnt, 2);
        chk("pre_rst_val", out_val, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_val", out_val, 0);
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", in_rdy, 1);
        step();
        step();
        rst = 1'b1;
        step();
        in_dat = 32'h0;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
        add_line(64'h0, 32, 1);
        collect(0, 100);
        for (int i = 0; i < 5; i++) begin
            chk("no_resume", out_val, 0);
            step();
        end

        // low nibble F: exercises the letter path
        in_dat = 32'h0000000F;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
        step();
        for (int i = 0; i < NP; i++) begin
            chk("f_val", out_val, 1);
            chk("f_dat", out_dat, seqp[i]);
            step();
        end
        chk("f_end", out_val, 0);

        // 8-bit LF-only instance: two queued lines, 1-cycle gap
        in_dat8 = 8'hA5;
        in_val8 = 1'b1;
        step();
        in_dat8 = 8'h3C;
        step();
        in_val8 = 1'b0;
        for (int ln = 0; ln < 2; ln++) begin
            for (int j = 0; j < N8; j++) begin
                chk("w8_val", out_val8, 1);
                chk("w8_dat", out_dat8, seq8[ln*N8 + j]);
                step();
            end
            chk("w8_gap", out_val8, 0);
            step();
        end
        chk("w8_busy_end", busy8, 0);
        chk("w8_val_end", out_val8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
